data_control: RTL and testbench

DATA_CONTROL -- requirements
Module: data_control

---
 rtl/data_control_pkg.sv | 58 +++++
 rtl/data_control_decode.sv | 74 +++++++
 rtl/data_control.sv | 44 ++++
 tb/tb_data_control.sv | 117 +++++++++++
 4 files changed

// File: rtl/data_control_pkg.sv
// Shared opcode, ALU-op and control-word definitions for the data_control decode stage.
package data_control_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_ANDI = 4'h6;
  localparam logic [3:0] OP_ORI  = 4'h7;
  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_SW   = 4'h9;
  localparam logic [3:0] OP_BEQ  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_HLT  = 4'hF;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam int CP_REG_WR      = 8;
  localparam int CP_MEM_RD      = 7;
  localparam int CP_MEM_WR      = 6;
  localparam int CP_MEM_TO_REG  = 5;
  localparam int CP_ALU_SRC_IMM = 4;
  localparam int CP_REG_DST_RD  = 3;
  localparam int CP_BRANCH      = 2;
  localparam int CP_JUMP        = 1;
  localparam int CP_HALT        = 0;

  typedef logic [8:0] ctrl_word_t;

  localparam ctrl_word_t CW_NOP  = 9'b000000000;
  localparam ctrl_word_t CW_HALT = 9'b000000001;

  // Builds a control word from its individual fields.
  function automatic ctrl_word_t make_ctrl(
    input logic reg_wr, input logic mem_rd, input logic mem_wr,
    input logic mem_to_reg, input logic alu_src_imm, input logic reg_dst_rd,
    input logic branch, input logic jump, input logic halt
  );
    ctrl_word_t w;
    w                 = CW_NOP;
    w[CP_REG_WR]      = reg_wr;
    w[CP_MEM_RD]      = mem_rd;
    w[CP_MEM_WR]      = mem_wr;
    w[CP_MEM_TO_REG]  = mem_to_reg;
    w[CP_ALU_SRC_IMM] = alu_src_imm;
    w[CP_REG_DST_RD]  = reg_dst_rd;
    w[CP_BRANCH]      = branch;
    w[CP_JUMP]        = jump;
    w[CP_HALT]        = halt;
    return w;
  endfunction

endpackage

// File: rtl/data_control_decode.sv
// Combinational opcode decoder producing the control word and ALU select.
module data_control_decode
  import data_control_pkg::*;
(
  input  logic [3:0] opcode,
  output ctrl_word_t ctrl_word,
  output logic [1:0] alu_op
);

  // Opcode to control word / ALU select table; reserved opcodes act as NOP.
  always_comb begin
    ctrl_word = CW_NOP;
    alu_op    = ALU_ADD;
    case (opcode)
      OP_NOP: begin
        ctrl_word = CW_NOP;
        alu_op    = ALU_ADD;
      end
      OP_ADD: begin
        ctrl_word = make_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        alu_op    = ALU_ADD;
      end
      OP_SUB: begin
        ctrl_word = make_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        alu_op    = ALU_SUB;
      end
      OP_AND: begin
        ctrl_word = make_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        alu_op    = ALU_AND;
      end
      OP_OR: begin
        ctrl_word = make_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        alu_op    = ALU_OR;
      end
      OP_ADDI: begin
        ctrl_word = make_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        alu_op    = ALU_ADD;
      end
      OP_ANDI: begin
        ctrl_word = make_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        alu_op    = ALU_AND;
      end
      OP_ORI: begin
        ctrl_word = make_ctrl(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        alu_op    = ALU_OR;
      end
      OP_LW: begin
        ctrl_word = make_ctrl(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        alu_op    = ALU_ADD;
      end
      OP_SW: begin
        ctrl_word = make_ctrl(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        alu_op    = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl_word = make_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        alu_op    = ALU_SUB;
      end
      OP_JMP: begin
        ctrl_word = make_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        alu_op    = ALU_ADD;
      end
      OP_HLT: begin
        ctrl_word = CW_HALT;
        alu_op    = ALU_ADD;
      end
      default: begin
        ctrl_word = CW_NOP;
        alu_op    = ALU_ADD;
      end
    endcase
  end

endmodule

// File: rtl/data_control.sv
// Decode stage control register: one-cycle registered decode with a sticky halt.
module data_control
  import data_control_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] OPcode,
  output logic [8:0] CONTROL_PIPE,
  output logic [1:0] ALU_OPcode
);

  ctrl_word_t dec_ctrl_s;
  logic [1:0] dec_alu_s;
  ctrl_word_t ctrl_r;
  logic [1:0] alu_r;
  logic       halt_r;

  data_control_decode u_decode (
    .opcode    (OPcode),
    .ctrl_word (dec_ctrl_s),
    .alu_op    (dec_alu_s)
  );

  // Output registers and halt flag; reset wins over any opcode, halt overrides decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_r <= CW_NOP;
      alu_r  <= ALU_ADD;
      halt_r <= 1'b0;
    end else if (halt_r) begin
      ctrl_r <= CW_HALT;
      alu_r  <= ALU_ADD;
      halt_r <= 1'b1;
    end else begin
      ctrl_r <= dec_ctrl_s;
      alu_r  <= dec_alu_s;
      halt_r <= (OPcode == OP_HLT);
    end
  end

  assign CONTROL_PIPE = ctrl_r;
  assign ALU_OPcode   = alu_r;

endmodule

// File: tb/tb_data_control.sv
// Randomized and directed self-checking bench for data_control against a table-driven reference model.
module tb_data_control;

  logic       clk;
  logic       rst;
  logic [3:0] opcode_s;
  logic [8:0] control_pipe_s;
  logic [1:0] alu_opcode_s;

  int checks_r;
  int errors_r;

  logic [8:0] ref_cw [16];
  logic [1:0] ref_alu [16];
  logic       ref_halted;
  logic [8:0] exp_cw;
  logic [1:0] exp_alu;

  data_control dut (
    .clk          (clk),
    .rst          (rst),
    .OPcode       (opcode_s),
    .CONTROL_PIPE (control_pipe_s),
    .ALU_OPcode   (alu_opcode_s)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_r++;
    if (obs !== exp) begin
      errors_r++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, compare outputs and invariants.
  task automatic step(input logic rst_in, input logic [3:0] op, input string tag);
    rst      = rst_in;
    opcode_s = op;
    @(posedge clk);
    #1;
    if (rst_in) begin
      exp_cw     = 9'b000000000;
      exp_alu    = 2'b00;
      ref_halted = 1'b0;
    end else if (ref_halted) begin
      exp_cw  = 9'b000000001;
      exp_alu = 2'b00;
    end else begin
      exp_cw  = ref_cw[op];
      exp_alu = ref_alu[op];
      if (op == 4'hF) ref_halted = 1'b1;
    end
    check_val({tag, "_cw"}, {23'd0, control_pipe_s}, {23'd0, exp_cw});
    check_val({tag, "_alu"}, {30'd0, alu_opcode_s}, {30'd0, exp_alu});
    check_val({tag, "_memrw"}, {31'd0, control_pipe_s[7] & control_pipe_s[6]}, 32'd0);
    check_val({tag, "_m2r"}, {31'd0, control_pipe_s[5] & ~control_pipe_s[7]}, 32'd0);
  endtask

  initial begin
    checks_r   = 0;
    errors_r   = 0;
    ref_halted = 1'b0;
    rst        = 1'b1;
    opcode_s   = 4'h0;
    for (int i = 0; i < 16; i++) begin
      ref_cw[i]  = 9'b000000000;
      ref_alu[i] = 2'b00;
    end
    ref_cw[1]  = 9'b100001000; ref_alu[1]  = 2'b00;
    ref_cw[2]  = 9'b100001000; ref_alu[2]  = 2'b01;
    ref_cw[3]  = 9'b100001000; ref_alu[3]  = 2'b10;
    ref_cw[4]  = 9'b100001000; ref_alu[4]  = 2'b11;
    ref_cw[5]  = 9'b100010000; ref_alu[5]  = 2'b00;
    ref_cw[6]  = 9'b100010000; ref_alu[6]  = 2'b10;
    ref_cw[7]  = 9'b100010000; ref_alu[7]  = 2'b11;
    ref_cw[8]  = 9'b110110000; ref_alu[8]  = 2'b00;
    ref_cw[9]  = 9'b001010000; ref_alu[9]  = 2'b00;
    ref_cw[10] = 9'b000000100; ref_alu[10] = 2'b01;
    ref_cw[11] = 9'b000000010; ref_alu[11] = 2'b00;
    ref_cw[15] = 9'b000000001; ref_alu[15] = 2'b00;

    // Reset with LW pending, then release.
    step(1'b1, 4'h8, "rst0");
    step(1'b1, 4'h8, "rst1");
    step(1'b0, 4'h8, "lw_after_rst");

    // Sweep of all non-halt opcodes including reserved ones.
    for (int op = 0; op <= 14; op++) step(1'b0, 4'(op), $sformatf("sweep_%0h", op));

    // Back-to-back SUB then SW.
    step(1'b0, 4'h2, "b2b_sub");
    step(1'b0, 4'h9, "b2b_sw");

    // Sticky halt then reset.
    step(1'b0, 4'hF, "hlt");
    for (int i = 0; i < 3; i++) step(1'b0, 4'h1, $sformatf("hlt_hold%0d", i));
    step(1'b1, 4'h1, "hlt_rst");

    // Reset coincident with HLT must not set halt.
    step(1'b1, 4'hF, "rst_hlt");
    step(1'b0, 4'h1, "no_halt");
    step(1'b0, 4'h4, "no_halt2");

    // Randomized opcodes with occasional resets.
    for (int i = 0; i < 1000; i++) begin
      step(($urandom_range(31, 0) == 0) ? 1'b1 : 1'b0, 4'($urandom_range(15, 0)), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
    $finish;
  end

endmodule
